mac_buf_seq: RTL and testbench
==============================

Name: mac_buf_seq

Overview:
- Sequencer for the 16-entry byte MAC line buffer (128-bit parallel load, 4-bit combinational read index).
- Accepts 128-bit lines from upstream through a valid/ready handshake and generates the buffer write-enable.
- Then steps the buffer read index 0..15 into the MAC datapath, honouring downstream backpressure.
- Also generates the accumulator clear/last strobes and reports job completion for a programmed number of lines.

Parameters:
- NUM_ELEM, 16: bytes per line, i.e. number of buffer entries stepped per line.
- IDX_W, 4: buffer index width; must satisfy 2**IDX_W >= NUM_ELEM.
- LINE_W, 8: width of the line-count field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- num_lines  in  LINE_W  lines in job; latched on accepted start.
- line_valid  in  1  upstream line available.
- line_ready  out  1  controller can accept a line this cycle.
- buf_we  out  1  buffer load strobe; equals line_valid & line_ready.
- buf_idx  out  IDX_W  buffer read index.
- mac_clr  out  1  one-cycle accumulator clear at job start.
- mac_en  out  1  MAC consumes buffer byte at buf_idx this cycle.
- mac_last  out  1  qualifies the final mac_en of the job.
- mac_ready  in  1  downstream can consume; low stalls the index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset, asynchronous, from any state: state=IDLE, idx=0, line and line counters=0. All outputs 0 (buf_idx=0) while rst_n is low and on the first cycle after release.
- States: IDLE, WAIT_LINE, STREAM, DONE.
- IDLE:
  - start=1 and num_lines=0: go to DONE, no mac_clr.
  - start=1 and num_lines!=0: latch num_lines, pulse mac_clr this cycle, go to WAIT_LINE.
- WAIT_LINE:
  - line_ready=1.
  - On line_valid=1: buf_we=1 this cycle, the buffer captures at this edge, idx<=0, go to STREAM.
- STREAM:
  - buf_idx=idx.
  - mac_en = mac_ready.
  - If mac_ready=0: hold idx, no mac_en.
  - On mac_en with idx<NUM_ELEM-1: idx++.
  - On mac_en with idx==NUM_ELEM-1: lines_done++, idx<=0.
    - If this was the final line: mac_last=1 this cycle, go to DONE.
    - Otherwise go to WAIT_LINE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- start while busy is ignored; num_lines changes after latch are ignored.
- Latency:
  - start (cycle 0) -> line accepted earliest cycle 1 -> first mac_en cycle 2.
  - Without stalls: NUM_ELEM+1 cycles per line.
  - done asserts the cycle after the final mac_en.
- buf_we is never asserted outside line acceptance, so buffer contents are stable throughout STREAM.
- Line counter compares against the latched value. num_lines=2**LINE_W-1 is legal: no wrap.
- buf_idx stays 0 in IDLE/WAIT_LINE/DONE.

Optional Feature:
- MAC_BUF_SEQ_OVERLAP_EN defined:
  - In STREAM, on the cycle with mac_en and idx==NUM_ELEM-1 and not the final line, line_ready=1.
  - A line accepted that cycle (buf_we=1) is safe: the read of entry NUM_ELEM-1 completes before the write edge.
  - The FSM then stays in STREAM with idx<=0, giving zero-bubble streaming of NUM_ELEM cycles per line.
  - If no line arrives that cycle, go to WAIT_LINE as normal.
- Undefined: line_ready only in WAIT_LINE, one bubble per line.

Decomposition:
- Package mac_seq_pkg: state enum (IDLE, WAIT_LINE, STREAM, DONE), NUM_ELEM/IDX_W/LINE_W defaults, LAST_IDX constant = NUM_ELEM-1.
- Sub-module mac_idx_counter: IDX_W counter with clear, enable and terminal-count output, reused for the index.
- The line counter is inline.

Test Plan:
- Basic job: num_lines=1, start, line_valid held high, mac_ready=1.
  - mac_clr at cycle 0, buf_we at cycle 1.
  - mac_en cycles 2..17 with buf_idx 0..15; mac_last at cycle 17; done at cycle 18; busy low at cycle 19.
- Backpressure: num_lines=1, mac_ready low on cycles 5-7.
  - buf_idx holds at 3 with mac_en=0 during the stall; 16 total mac_en; done at cycle 21.
- Multi-line, macro off: num_lines=3, line_valid constant.
  - buf_we at cycles 1, 18, 35; mac_last only at cycle 51; done at cycle 52.
- Multi-line, MAC_BUF_SEQ_OVERLAP_EN: num_lines=3.
  - buf_we at cycles 1, 17, 33; mac_last at cycle 49; buf_idx sequence continuous 0..15 x3.
- Edge cases:
  - num_lines=0: done at cycle 1, no mac_clr, buf_we or mac_en.
  - start pulsed while busy: no effect.
- Reset mid-STREAM: rst_n low at idx=7.
  - All outputs 0 immediately; after release, IDLE ignores line_valid until a new start.

Source files
------------

// File: rtl/mac_buf_seq_pkg.sv
// Shared types and default sizes for the MAC line-buffer sequencer.
// Imported by mac_buf_seq and mac_idx_counter.
package mac_seq_pkg;

  localparam int DEF_NUM_ELEM = 16;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_LINE_W   = 8;
  localparam int LAST_IDX     = DEF_NUM_ELEM - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    STREAM    = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/mac_buf_seq_idx_counter.sv
// Buffer index counter: synchronous clear, count enable, wraps to zero
// after the terminal count, which is also reported on tc.
module mac_idx_counter
  import mac_seq_pkg::*;
#(
  parameter int W    = DEF_IDX_W,
  parameter int LAST = LAST_IDX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/mac_buf_seq.sv
// Sequencer for the 16-entry MAC line buffer: line load handshake, index stepping,
// accumulator strobes. Define MAC_BUF_SEQ_OVERLAP_EN for zero-bubble line reload.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_LINE | line_ready high, waiting for upstream line
// STREAM    | stepping buf_idx into the MAC, stalls on mac_ready low
// DONE      | one-cycle done pulse, then IDLE
module mac_buf_seq
  import mac_seq_pkg::*;
#(
  parameter int NUM_ELEM = DEF_NUM_ELEM,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int LINE_W   = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LINE_W-1:0] num_lines,
  input  logic              line_valid,
  output logic              line_ready,
  output logic              buf_we,
  output logic [IDX_W-1:0]  buf_idx,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              mac_last,
  input  logic              mac_ready,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              armed;
  logic [LINE_W-1:0] num_lat;
  logic [LINE_W-1:0] lines_cnt;
  logic [IDX_W-1:0]  idx;
  logic              idx_tc;
  logic              last_line;
  logic              overlap_ok;

  mac_idx_counter #(
    .W    (IDX_W),
    .LAST (NUM_ELEM - 1)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != STREAM),
    .en    (mac_en),
    .cnt   (idx),
    .tc    (idx_tc)
  );

  // Comparing against latched count minus one keeps num_lines = max free of wrap.
  assign last_line = (lines_cnt == num_lat - LINE_W'(1));

`ifdef MAC_BUF_SEQ_OVERLAP_EN
  // Entry NUM_ELEM-1 is read combinationally before this edge rewrites the buffer.
  assign overlap_ok = (state == STREAM) && mac_ready && idx_tc && !last_line;
`else
  assign overlap_ok = 1'b0;
`endif

  assign line_ready = (state == WAIT_LINE) || overlap_ok;
  assign buf_we     = line_valid && line_ready;
  assign buf_idx    = idx;
  assign mac_en     = (state == STREAM) && mac_ready;
  assign mac_last   = mac_en && idx_tc && last_line;
  assign mac_clr    = (state == IDLE) && armed && start && (num_lines != '0);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // armed keeps every output quiet on the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      num_lat   <= '0;
      lines_cnt <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && start) begin
            if (num_lines == '0) begin
              state <= DONE;
            end else begin
              num_lat   <= num_lines;
              lines_cnt <= '0;
              state     <= WAIT_LINE;
            end
          end
        end
        WAIT_LINE: begin
          if (line_valid) state <= STREAM;
        end
        STREAM: begin
          if (mac_en && idx_tc) begin
            lines_cnt <= lines_cnt + LINE_W'(1);
            if (last_line)   state <= DONE;
            else if (buf_we) state <= STREAM;
            else             state <= WAIT_LINE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_buf_seq.sv
// Self-checking bench for mac_buf_seq: directed timing scenarios plus randomized
// jobs checked against a transaction-level reference model.
module tb_mac_buf_seq;

`ifdef MAC_BUF_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam int MAXC = 4400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_lines;
  logic       line_valid;
  logic       line_ready;
  logic       buf_we;
  logic [3:0] buf_idx;
  logic       mac_clr;
  logic       mac_en;
  logic       mac_last;
  logic       mac_ready;
  logic       busy;
  logic       done;

  logic [10:0] out_vec;
  assign out_vec = {line_ready, buf_we, buf_idx, mac_clr, mac_en, mac_last, busy, done};

  mac_buf_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_lines  (num_lines),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .buf_we     (buf_we),
    .buf_idx    (buf_idx),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .mac_last   (mac_last),
    .mac_ready  (mac_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit lv_pat[MAXC];
  bit mr_pat[MAXC];
  bit st_pat[MAXC];

  logic       tr_rdy[MAXC], tr_we[MAXC], tr_clr[MAXC], tr_en[MAXC];
  logic       tr_last[MAXC], tr_busy[MAXC], tr_done[MAXC];
  logic [3:0] tr_idx[MAXC];

  bit e_rdy[MAXC], e_we[MAXC], e_clr[MAXC], e_en[MAXC];
  bit e_last[MAXC], e_busy[MAXC], e_done[MAXC];
  int e_idx[MAXC];
  int end_t;

  task automatic fill(input bit lv, input bit mr);
    for (int c = 0; c < MAXC; c++) begin
      lv_pat[c] = lv;
      mr_pat[c] = mr;
      st_pat[c] = 1'b0;
    end
  endtask

  // Reference: walk the job as lines and bytes, advancing time on every wait.
  task automatic model(input int nl);
    int t;
    bit have;
    for (int c = 0; c < MAXC; c++) begin
      e_rdy[c] = 0; e_we[c] = 0; e_clr[c] = 0; e_en[c] = 0;
      e_last[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_idx[c] = 0;
    end
    e_clr[0] = (nl != 0);
    t = 1;
    have = 1'b0;
    for (int ln = 0; ln < nl; ln++) begin
      if (!have) begin
        while (!lv_pat[t] && t < MAXC - 40) begin e_rdy[t] = 1; t++; end
        e_rdy[t] = 1;
        e_we[t]  = 1;
        t++;
      end
      have = 1'b0;
      for (int b = 0; b < 16; b++) begin
        while (!mr_pat[t] && t < MAXC - 40) begin e_idx[t] = b; t++; end
        e_idx[t] = b;
        e_en[t]  = 1;
        if (b == 15 && ln == nl - 1) e_last[t] = 1;
        if (b == 15 && ln != nl - 1 && OVL) begin
          e_rdy[t] = 1;
          if (lv_pat[t]) begin e_we[t] = 1; have = 1'b1; end
        end
        t++;
      end
    end
    end_t = t;
    e_done[end_t] = 1;
    for (int c = 1; c <= end_t; c++) e_busy[c] = 1;
  endtask

  // Drives one job starting at cycle 0; entered and left at posedge+1.
  task automatic run_job(input logic [7:0] nl, input int ncyc);
    st_pat[0] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      start      = st_pat[c];
      num_lines  = (c == 0) ? nl : 8'($urandom_range(0, 255));
      line_valid = lv_pat[c];
      mac_ready  = mr_pat[c];
      @(negedge clk);
      tr_rdy[c] = line_ready; tr_we[c] = buf_we; tr_clr[c] = mac_clr;
      tr_en[c] = mac_en; tr_last[c] = mac_last; tr_busy[c] = busy;
      tr_done[c] = done; tr_idx[c] = buf_idx;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    line_valid = 1'b0;
    mac_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; num_lines = 8'd5; line_valid = 1'b1; mac_ready = 1'b1;
    #12;
    checks++;
    if (out_vec !== 11'd0) begin errors++; $display("FAIL reset_outputs got %b want 0", out_vec); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_vec !== 11'd0) begin errors++; $display("FAIL first_cycle_after_release got %b want 0", out_vec); end
    @(posedge clk); #1;
    start = 1'b0; line_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fill(1, 1);
    run_job(8'd1, 22);
    checks++;
    if (tr_clr[0] !== 1'b1 || tr_we[1] !== 1'b1) begin
      errors++; $display("FAIL basic_clr_we got clr0=%b we1=%b want 1 1", tr_clr[0], tr_we[1]);
    end
    for (int c = 2; c <= 17; c++) begin
      checks++;
      if (tr_en[c] !== 1'b1 || tr_idx[c] !== 4'(c - 2)) begin
        errors++; $display("FAIL basic_idx cycle %0d got en=%b idx=%0d want en=1 idx=%0d", c, tr_en[c], tr_idx[c], c - 2);
      end
    end
    checks++;
    if (tr_last[17] !== 1'b1 || tr_last[16] !== 1'b0 || tr_done[18] !== 1'b1 || tr_busy[18] !== 1'b1 || tr_busy[19] !== 1'b0) begin
      errors++; $display("FAIL basic_end got last17=%b last16=%b done18=%b busy18=%b busy19=%b want 1 0 1 1 0",
                         tr_last[17], tr_last[16], tr_done[18], tr_busy[18], tr_busy[19]);
    end
  endtask

  task automatic test_backpressure();
    int n_en;
    fill(1, 1);
    for (int c = 5; c <= 7; c++) mr_pat[c] = 1'b0;
    run_job(8'd1, 25);
    for (int c = 5; c <= 7; c++) begin
      checks++;
      if (tr_idx[c] !== 4'd3 || tr_en[c] !== 1'b0) begin
        errors++; $display("FAIL stall_hold cycle %0d got idx=%0d en=%b want idx=3 en=0", c, tr_idx[c], tr_en[c]);
      end
    end
    n_en = 0;
    for (int c = 0; c < 25; c++) if (tr_en[c] === 1'b1) n_en++;
    checks++;
    if (n_en != 16 || tr_last[20] !== 1'b1 || tr_done[21] !== 1'b1) begin
      errors++; $display("FAIL stall_totals got en=%0d last20=%b done21=%b want 16 1 1", n_en, tr_last[20], tr_done[21]);
    end
  endtask

  task automatic test_multi();
    int n_we, n_last, k, w1, w2, lc, dc;
    fill(1, 1);
    run_job(8'd3, 56);
    w1 = OVL ? 17 : 18;
    w2 = OVL ? 33 : 35;
    lc = OVL ? 49 : 51;
    dc = OVL ? 50 : 52;
    n_we = 0; n_last = 0; k = 0;
    for (int c = 0; c < 56; c++) begin
      if (tr_we[c] === 1'b1) n_we++;
      if (tr_last[c] === 1'b1) n_last++;
      if (tr_en[c] === 1'b1) begin
        checks++;
        if (tr_idx[c] !== 4'(k % 16)) begin
          errors++; $display("FAIL multi_idx cycle %0d got %0d want %0d", c, tr_idx[c], k % 16);
        end
        k++;
      end
    end
    checks++;
    if (n_we != 3 || tr_we[1] !== 1'b1 || tr_we[w1] !== 1'b1 || tr_we[w2] !== 1'b1) begin
      errors++; $display("FAIL multi_we got count=%0d at %0d/%0d/%0d=%b%b%b want 3 111", n_we, 1, w1, w2, tr_we[1], tr_we[w1], tr_we[w2]);
    end
    checks++;
    if (k != 48 || n_last != 1 || tr_last[lc] !== 1'b1 || tr_done[dc] !== 1'b1) begin
      errors++; $display("FAIL multi_end got en=%0d lasts=%0d last@%0d=%b done@%0d=%b want 48 1 1 1", k, n_last, lc, tr_last[lc], dc, tr_done[dc]);
    end
  endtask

  task automatic test_zero_lines();
    int n_act;
    fill(1, 1);
    run_job(8'd0, 6);
    n_act = 0;
    for (int c = 0; c < 6; c++) if (tr_clr[c] === 1'b1 || tr_we[c] === 1'b1 || tr_en[c] === 1'b1) n_act++;
    checks++;
    if (n_act != 0 || tr_done[1] !== 1'b1 || tr_busy[1] !== 1'b1 || tr_busy[2] !== 1'b0) begin
      errors++; $display("FAIL zero_lines got strobes=%0d done1=%b busy1=%b busy2=%b want 0 1 1 0", n_act, tr_done[1], tr_busy[1], tr_busy[2]);
    end
  endtask

  task automatic test_start_while_busy();
    int n_done, n_clr;
    fill(1, 1);
    st_pat[1] = 1; st_pat[5] = 1; st_pat[10] = 1; st_pat[18] = 1;
    run_job(8'd1, 26);
    n_done = 0; n_clr = 0;
    for (int c = 0; c < 26; c++) begin
      if (tr_done[c] === 1'b1) n_done++;
      if (tr_clr[c] === 1'b1) n_clr++;
    end
    checks++;
    if (n_done != 1 || n_clr != 1 || tr_done[18] !== 1'b1 || tr_busy[19] !== 1'b0) begin
      errors++; $display("FAIL busy_start got dones=%0d clrs=%0d done18=%b busy19=%b want 1 1 1 0", n_done, n_clr, tr_done[18], tr_busy[19]);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    start = 1'b1; num_lines = 8'd2; line_valid = 1'b1; mac_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (mac_en === 1'b1 && buf_idx === 4'd7) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_reach_idx7 got timeout want idx 7"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vec !== 11'd0) begin errors++; $display("FAIL reset_mid_outputs got %b want 0", out_vec); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec !== 11'd0) begin errors++; $display("FAIL reset_mid_release got %b want 0", out_vec); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (buf_we !== 1'b0 || busy !== 1'b0 || line_ready !== 1'b0) begin
        errors++; $display("FAIL reset_mid_idle got we=%b busy=%b rdy=%b want 0 0 0", buf_we, busy, line_ready);
      end
    end
    @(posedge clk); #1;
    line_valid = 1'b0;
    fill(1, 1);
    run_job(8'd1, 22);
    checks++;
    if (tr_done[OVL ? 18 : 18] !== 1'b1 || tr_clr[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_restart got done18=%b clr0=%b want 1 1", tr_done[18], tr_clr[0]);
    end
  endtask

  task automatic test_max_lines();
    int n_last, dc;
    fill(1, 1);
    dc = OVL ? (16 * 255 + 2) : (17 * 255 + 1);
    run_job(8'd255, dc + 3);
    n_last = 0;
    for (int c = 0; c < dc + 3; c++) if (tr_last[c] === 1'b1) n_last++;
    checks++;
    if (n_last != 1 || tr_last[dc - 1] !== 1'b1 || tr_done[dc] !== 1'b1 || tr_busy[dc + 1] !== 1'b0) begin
      errors++; $display("FAIL max_lines got lasts=%0d last=%b done=%b busy_after=%b want 1 1 1 0",
                         n_last, tr_last[dc - 1], tr_done[dc], tr_busy[dc + 1]);
    end
  endtask

  task automatic test_random();
    int nl, ncyc, nfail;
    for (int it = 0; it < 8; it++) begin
      nl = (it == 3) ? 0 : $urandom_range(1, 4);
      for (int c = 0; c < MAXC; c++) begin
        lv_pat[c] = ($urandom_range(0, 3) != 0);
        mr_pat[c] = ($urandom_range(0, 3) != 0);
        st_pat[c] = 1'b0;
      end
      model(nl);
      for (int c = 1; c <= end_t; c++) st_pat[c] = ($urandom_range(0, 3) == 0);
      ncyc = end_t + 4;
      run_job(8'(nl), ncyc);
      nfail = 0;
      for (int c = 0; c < ncyc; c++) begin
        checks++;
        if (tr_rdy[c] !== e_rdy[c] || tr_we[c] !== e_we[c] || tr_clr[c] !== e_clr[c] ||
            tr_en[c] !== e_en[c] || tr_last[c] !== e_last[c] || tr_busy[c] !== e_busy[c] ||
            tr_done[c] !== e_done[c] || tr_idx[c] !== 4'(e_idx[c])) begin
          errors++;
          if (nfail < 10)
            $display("FAIL random it%0d cycle %0d got rdy/we/clr/en/last/busy/done=%b%b%b%b%b%b%b idx=%0d want %b%b%b%b%b%b%b idx=%0d",
                     it, c, tr_rdy[c], tr_we[c], tr_clr[c], tr_en[c], tr_last[c], tr_busy[c], tr_done[c], tr_idx[c],
                     e_rdy[c], e_we[c], e_clr[c], e_en[c], e_last[c], e_busy[c], e_done[c], e_idx[c]);
          nfail++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_multi();
    test_zero_lines();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_max_lines();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
